serial_adder_ctrl: RTL and testbench
====================================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 The block SHALL have one clock, clk: all state SHALL update on its rising edge.
REQ-003 The block SHALL have reset rst: synchronous, active-high.
REQ-004 Ports SHALL be, in this order:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  request to begin an addition
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in
- busy  out  1  high while bit-serial addition is in progress
- done  out  1  one-cycle pulse when the result is valid
- sum  out  WIDTH  result
- cout  out  1  carry-out

Function
REQ-005 The block SHALL compute {cout,sum} = a + b + cin using one 1-bit adder cell, time-shared over WIDTH cycles, LSB first.
REQ-006 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-007 FSM transitions SHALL be:
- IDLE -> SHIFT on start=1
- SHIFT -> DONE after exactly WIDTH SHIFT cycles
- DONE -> SHIFT if start=1, else DONE -> IDLE
REQ-008 On acceptance of start, the block SHALL latch a, b and cin into internal shift and carry registers and clear the bit counter to 0.
REQ-009 In each SHIFT cycle the block SHALL:
- form the bit a_sh[0]^b_sh[0]^carry and shift it into the MSB of the partial-sum register
- shift a_sh and b_sh right by one
- update carry with the cell carry-out
- increment the counter
REQ-010 The counter SHALL be clog2(WIDTH+1) bits wide; SHIFT SHALL exit when counter == WIDTH-1 at the clock edge.
REQ-011 Latency: with start high in cycle 0, busy SHALL be 1 in cycles 1..WIDTH and done SHALL be 1 only in cycle WIDTH+1.
REQ-012 sum and cout SHALL load from the partial-sum and carry registers only on the SHIFT->DONE edge, and SHALL hold that value until the next such edge.
REQ-013 start SHALL be ignored while busy=1; operands changing during SHIFT SHALL NOT affect the result.
REQ-014 start in the DONE cycle SHALL be accepted (back-to-back operation): busy=1 in the next cycle while sum still holds the previous result.
REQ-015 busy and done SHALL never be 1 simultaneously.

Reset
REQ-016 When rst=1 at a clock edge, the block SHALL enter IDLE and clear busy, done, sum, cout, the counter, the carry and all shift registers to 0.
REQ-017 rst SHALL take priority over start; reset during SHIFT SHALL abort the operation with no done pulse.
REQ-018 start SHALL be honoured on the first edge after rst deasserts.

Structure
REQ-019 A shared package SHALL hold the FSM state encoding (2-bit: IDLE=0, SHIFT=1, DONE=2) and the default WIDTH constant.
REQ-020 The 1-bit cell SHALL be a sub-module, fulladder_bit (a, b, cin -> s, cout), built at gate level from two half-adder stages and an OR.
REQ-021 The controller SHALL contain only registers, the FSM and the counter, with no inline multi-bit adder.

Verification
REQ-022 The bench SHALL cover these directed scenarios at WIDTH=8:
- a=8'hFF, b=8'h01, cin=0, start pulse in cycle 0 -> done in cycle 9; sum=8'h00, cout=1; busy high in cycles 1..8.
- a=8'h5A, b=8'h25, cin=1 -> sum=8'h80, cout=0.
- Back-to-back: 8'h0F+8'h01 then start in the DONE cycle with 8'h10+8'h10 -> sum=8'h10 then sum=8'h20; two done pulses 9 cycles apart.
- start re-pulsed and a changed to 8'h00 in cycle 4 of an 8'h03+8'h04 operation -> ignored; sum=8'h07.
- rst asserted in cycle 5 of an operation -> no done; sum=0; busy=0 from the next cycle.
- Random 1000 operations -> {cout,sum} equals a+b+cin every time; busy and done never both high.

Source files
------------

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encoding and default width.
package serial_adder_ctrl_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : serial_adder_ctrl_pkg

// File: rtl/serial_adder_ctrl_fulladder_bit.sv
// Gate-level 1-bit full adder: two half-adder stages whose carries are ORed.
module fulladder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;
    logic g;
    logic c2;

    // First half adder on the operand bits
    xor u_ha0_x (p, a, b);
    and u_ha0_a (g, a, b);

    // Second half adder folds in the incoming carry
    xor u_ha1_x (s, p, cin);
    and u_ha1_a (c2, p, cin);

    or  u_cor   (cout, g, c2);

endmodule : fulladder_bit

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared full-adder cell computes {cout,sum} = a + b + cin LSB first over WIDTH cycles.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] psum;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             load_c;
    logic             shift_c;
    logic             finish_c;
    logic             bit_s;
    logic             bit_c;

    fulladder_bit u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (bit_s),
        .cout (bit_c)
    );

    // Next-state and datapath control
    always_comb begin
        state_nxt = state;
        load_c    = 1'b0;
        shift_c   = 1'b0;
        finish_c  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                    load_c    = 1'b1;
                end
            end
            SHIFT: begin
                shift_c = 1'b1;
                if (cnt == CNT_LAST) begin
                    state_nxt = DONE;
                    finish_c  = 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    state_nxt = SHIFT;
                    load_c    = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == SHIFT);
            done  <= (state_nxt == DONE);
            if (load_c) begin
                a_sh  <= a;
                b_sh  <= b;
                carry <= cin;
                psum  <= '0;
                cnt   <= '0;
            end else if (shift_c) begin
                a_sh  <= a_sh >> 1;
                b_sh  <= b_sh >> 1;
                psum  <= {bit_s, psum[WIDTH-1:1]};
                carry <= bit_c;
                cnt   <= cnt + CNT_W'(1);
            end
            // Final bit is folded in on the same edge the result is published
            if (finish_c) begin
                sum  <= {bit_s, psum[WIDTH-1:1]};
                cout <= bit_c;
            end
        end
    end

endmodule : serial_adder_ctrl

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random self-checking bench for serial_adder_ctrl at WIDTH=8.
module tb_serial_adder_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    int checks = 0;
    int errors = 0;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full operation from a start pulse to done, with bounded wait
    task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic vc);
        logic [8:0] exp;
        int cyc;
        exp   = {1'b0, va} + {1'b0, vb} + {8'd0, vc};
        a     = va;
        b     = vb;
        cin   = vc;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < 40) begin
            check("busy_done_excl", {31'd0, busy & done}, 32'd0);
            tick();
            cyc++;
        end
        check("rand_done_seen", {31'd0, done}, 32'd1);
        check("rand_latency", 32'(cyc), 32'd9);
        check("rand_busy_at_done", {31'd0, busy}, 32'd0);
        check("rand_result", {23'd0, cout, sum}, {23'd0, exp});
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        cin   = 1'b0;
        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum",  {24'd0, sum},  32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);

        // FF + 01, start on the first edge after reset release
        rst   = 1'b0;
        a     = 8'hFF;
        b     = 8'h01;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check("s1_busy", {31'd0, busy}, 32'd1);
            check("s1_done_early", {31'd0, done}, 32'd0);
            tick();
        end
        check("s1_done", {31'd0, done}, 32'd1);
        check("s1_busy_off", {31'd0, busy}, 32'd0);
        check("s1_sum", {24'd0, sum}, 32'h00);
        check("s1_cout", {31'd0, cout}, 32'd1);
        tick();
        check("s1_done_pulse", {31'd0, done}, 32'd0);
        check("s1_sum_hold", {24'd0, sum}, 32'h00);

        // 5A + 25 + 1
        run_op(8'h5A, 8'h25, 1'b1);
        check("s2_sum", {24'd0, sum}, 32'h80);
        check("s2_cout", {31'd0, cout}, 32'd0);
        tick();

        // Back-to-back: second start in the DONE cycle
        a     = 8'h0F;
        b     = 8'h01;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 8; c++) tick();
        check("s3_done1", {31'd0, done}, 32'd1);
        check("s3_sum1", {24'd0, sum}, 32'h10);
        a     = 8'h10;
        b     = 8'h10;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("s3_busy_b2b", {31'd0, busy}, 32'd1);
        check("s3_sum_held", {24'd0, sum}, 32'h10);
        for (int c = 10; c <= 17; c++) begin
            check("s3_no_early_done", {31'd0, done}, 32'd0);
            tick();
        end
        check("s3_done2", {31'd0, done}, 32'd1);
        check("s3_sum2", {24'd0, sum}, 32'h20);
        check("s3_cout2", {31'd0, cout}, 32'd0);
        tick();

        // start re-pulsed and operand changed mid-operation
        a     = 8'h03;
        b     = 8'h04;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        start = 1'b1;
        a     = 8'h00;
        tick();
        start = 1'b0;
        for (int c = 5; c <= 8; c++) tick();
        check("s4_done", {31'd0, done}, 32'd1);
        check("s4_sum", {24'd0, sum}, 32'h07);
        tick();
        check("s4_idle_done", {31'd0, done}, 32'd0);
        check("s4_idle_busy", {31'd0, busy}, 32'd0);

        // Reset in cycle 5 aborts the operation
        a     = 8'h33;
        b     = 8'h44;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 4; c++) tick();
        rst = 1'b1;
        tick();
        check("s5_busy", {31'd0, busy}, 32'd0);
        check("s5_done", {31'd0, done}, 32'd0);
        check("s5_sum", {24'd0, sum}, 32'd0);
        check("s5_cout", {31'd0, cout}, 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            check("s5_no_done", {31'd0, done}, 32'd0);
            tick();
        end

        // Random operations
        for (int n = 0; n < 1000; n++) begin
            run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_serial_adder_ctrl
